// File: rtl/regfile_pkg.sv
// Shared constants and address-qualification helpers for the multi-port
// register file and its busy scoreboard. Both the storage core and the
// scoreboard use the same rules for which addresses are live, so a write,
// a claim and a read of the same address are always treated alike.
package regfile_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 8;
  localparam int NUM_RD_DEF = 2;

  // True when addr names a physically present entry. DEPTH need not be a
  // power of two, so the top addresses of the ADDR_W space may be dead.
  function automatic logic addr_in_range(input int unsigned addr, input int depth);
    return (depth > 0) && (addr < unsigned'(depth));
  endfunction

  // True when addr is the hardwired-zero entry of a ZERO_REG build.
  function automatic logic is_zero_entry(input int unsigned addr, input int zero_reg);
    return (zero_reg != 0) && (addr == 0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-entry busy scoreboard. Decode claims an entry when it issues an
// instruction writing that entry; writeback releases it when the result
// lands. rd_busy gives each read port the busy bit of its addressed entry
// for issue-stage hazard checks.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [DEPTH-1:0]         busy,
  output logic [NUM_RD-1:0]        rd_busy
);

  logic release_ok;
  logic claim_ok;

  // Dead addresses and the hardwired-zero entry never take part in
  // scoreboarding, so neither a release nor a claim to them does anything.
  assign release_ok = wr_en
                   && addr_in_range(32'(wr_addr), DEPTH)
                   && !is_zero_entry(32'(wr_addr), ZERO_REG);
  assign claim_ok   = claim_en
                   && addr_in_range(32'(claim_addr), DEPTH)
                   && !is_zero_entry(32'(claim_addr), ZERO_REG);

  // Busy vector update: a claim in the same cycle as a release of the same
  // entry wins, because the newly issued producer supersedes the retiring one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (claim_ok && (claim_addr == ADDR_W'(i))) begin
          busy[i] <= 1'b1;
        end else if (release_ok && (wr_addr == ADDR_W'(i))) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_busy
    logic [ADDR_W-1:0] addr;
    logic              hit;

    assign addr = rd_addr[p*ADDR_W +: ADDR_W];

    // Lookup from the registered busy vector only; a release happening this
    // cycle is deliberately not forwarded, the hazard clears next cycle.
    always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (addr == ADDR_W'(i)) begin
          hit = busy[i];
        end
      end
      if (!addr_in_range(32'(addr), DEPTH) || is_zero_entry(32'(addr), ZERO_REG)) begin
        hit = 1'b0;
      end
    end

    assign rd_busy[p] = hit;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with one write port,
// optional hardwired-zero entry 0, write-to-read bypass, optional
// registered read data and a per-entry busy scoreboard. Decode reads and
// claims entries; writeback writes and releases them.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int DEPTH    = DEPTH_DEF,
  parameter  int NUM_RD   = NUM_RD_DEF,
  parameter  int ZERO_REG = 0,
  parameter  int BYPASS   = 1,
  parameter  int RD_REG   = 0,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic [DEPTH-1:0]         busy,
  output logic [NUM_RD-1:0]        rd_busy
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;

  // A write only counts when it lands on a real, writable entry; the same
  // qualified strobe gates both storage and bypass so they never disagree.
  assign wr_ok = wr_en
              && addr_in_range(32'(wr_addr), DEPTH)
              && !is_zero_entry(32'(wr_addr), ZERO_REG);

  // Storage: every entry clears on reset; a qualified write updates one entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_ok && (wr_addr == ADDR_W'(i))) begin
          mem[i] <= wr_data;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rd_val;

    assign addr = rd_addr[p*ADDR_W +: ADDR_W];

    // Read mux with optional forwarding of this cycle's write. Ports are
    // independent copies of the same logic, so ports on one address agree.
    always_comb begin
      rd_val = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (addr == ADDR_W'(i)) begin
          rd_val = mem[i];
        end
      end
      if ((BYPASS != 0) && wr_ok && (wr_addr == addr)) begin
        rd_val = wr_data;
      end
      if (!addr_in_range(32'(addr), DEPTH) || is_zero_entry(32'(addr), ZERO_REG)) begin
        rd_val = '0;
      end
    end

    if (RD_REG != 0) begin : g_reg
      logic [DATA_W-1:0] rd_q;

      // Registered read: the muxed (and possibly bypassed) value appears the
      // cycle after the address was presented.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_q <= '0;
        end else begin
          rd_q <= rd_val;
        end
      end

      assign rd_data[p*DATA_W +: DATA_W] = rd_q;
    end else begin : g_comb
      assign rd_data[p*DATA_W +: DATA_W] = rd_val;
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .rd_addr    (rd_addr),
    .busy       (busy),
    .rd_busy    (rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp. Two builds share one stimulus stream:
//   config 0 (dut_a): DEPTH 8, no zero entry, bypass on, combinational read
//   config 1 (dut_b): DEPTH 6, zero entry, bypass off, registered read
// Both are checked every cycle against an array-based reference model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [5:0]  rd_addr;
  logic        claim_en;
  logic [2:0]  claim_addr;

  logic [31:0] rd_data_a, rd_data_b;
  logic [7:0]  busy_a;
  logic [5:0]  busy_b;
  logic [1:0]  rd_busy_a, rd_busy_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W(16), .DEPTH(8), .NUM_RD(2), .ZERO_REG(0), .BYPASS(1), .RD_REG(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .claim_en(claim_en), .claim_addr(claim_addr),
    .busy(busy_a), .rd_busy(rd_busy_a)
  );

  regfile_mp #(
    .DATA_W(16), .DEPTH(6), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0), .RD_REG(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .claim_en(claim_en), .claim_addr(claim_addr),
    .busy(busy_b), .rd_busy(rd_busy_b)
  );

  // Reference state, indexed by config.
  logic [15:0] m_mem  [2][8];
  logic [7:0]  m_busy [2];
  logic [15:0] m_rdq  [2][2];

  function automatic int dep(input int c);
    return (c == 0) ? 8 : 6;
  endfunction
  function automatic bit zr(input int c);
    return c == 1;
  endfunction
  function automatic bit byp(input int c);
    return c == 0;
  endfunction
  function automatic bit rr(input int c);
    return c == 1;
  endfunction

  function automatic bit live(input int c, input logic [2:0] a);
    return (int'(a) < dep(c)) && !(zr(c) && (a == 3'd0));
  endfunction

  function automatic logic [15:0] exp_rd(input int c, input logic [2:0] a);
    if (!live(c, a)) return 16'h0000;
    if (byp(c) && wr_en && live(c, wr_addr) && (wr_addr == a)) return wr_data;
    return m_mem[c][a];
  endfunction

  function automatic logic exp_rbusy(input int c, input logic [2:0] a);
    if (!live(c, a)) return 1'b0;
    return m_busy[c][a];
  endfunction

  function automatic logic [15:0] obs_rd(input int c, input int p);
    return (c == 0) ? rd_data_a[p*16 +: 16] : rd_data_b[p*16 +: 16];
  endfunction
  function automatic logic obs_rbusy(input int c, input int p);
    return (c == 0) ? rd_busy_a[p] : rd_busy_b[p];
  endfunction
  function automatic logic [31:0] obs_busy(input int c);
    return (c == 0) ? {24'b0, busy_a} : {26'b0, busy_b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 8; i++) m_mem[c][i] = 16'h0000;
      m_busy[c]   = 8'h00;
      m_rdq[c][0] = 16'h0000;
      m_rdq[c][1] = 16'h0000;
    end
  endtask

  task automatic model_check();
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < 2; p++) begin
        logic [2:0]  a;
        logic [15:0] e;
        a = rd_addr[p*3 +: 3];
        e = rr(c) ? m_rdq[c][p] : exp_rd(c, a);
        chk($sformatf("cfg%0d_rd%0d_addr%0d", c, p, a), 32'(obs_rd(c, p)), 32'(e));
        chk($sformatf("cfg%0d_rd_busy%0d_addr%0d", c, p, a), 32'(obs_rbusy(c, p)), 32'(exp_rbusy(c, a)));
      end
      chk($sformatf("cfg%0d_busy", c), obs_busy(c), 32'(m_busy[c]));
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, then check.
  task automatic apply(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic ce, input logic [2:0] ca,
                       input logic [2:0] ra0, input logic [2:0] ra1);
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    claim_en   = ce;
    claim_addr = ca;
    rd_addr    = {ra1, ra0};
    #1;
    model_check();
  endtask

  // Advance the model across the rising edge using the inputs now applied.
  task automatic advance();
    logic [15:0] nq   [2][2];
    logic [15:0] nmem [2][8];
    logic [7:0]  nbusy[2];
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < 2; p++) nq[c][p] = exp_rd(c, rd_addr[p*3 +: 3]);
      for (int i = 0; i < 8; i++) nmem[c][i] = m_mem[c][i];
      nbusy[c] = m_busy[c];
      if (wr_en && live(c, wr_addr)) begin
        nmem[c][wr_addr]  = wr_data;
        nbusy[c][wr_addr] = 1'b0;
      end
      if (claim_en && live(c, claim_addr)) nbusy[c][claim_addr] = 1'b1;
    end
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < 2; p++) m_rdq[c][p] = nq[c][p];
      for (int i = 0; i < 8; i++) m_mem[c][i] = nmem[c][i];
      m_busy[c] = nbusy[c];
    end
    @(negedge clk);
  endtask

  // Assert reset in the middle of a cycle and check that state clears at once.
  task automatic reset_pulse();
    wr_en    = 1'b0;
    claim_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy_a_now", 32'(busy_a), 32'h0);
    chk("rst_busy_b_now", 32'(busy_b), 32'h0);
    for (int a = 0; a < 8; a++) begin
      logic [2:0] av;
      av = a[2:0];
      rd_addr = {av, av};
      #1;
      model_check();
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = 3'd0;
    wr_data    = 16'h0000;
    rd_addr    = 6'd0;
    claim_en   = 1'b0;
    claim_addr = 3'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Out of reset: everything reads zero, nothing busy.
    apply(0, 3'd0, 16'h0, 0, 3'd0, 3'd1, 3'd2);
    chk("reset_rd0_a", 32'(rd_data_a[15:0]), 32'h0);
    chk("reset_busy_a", 32'(busy_a), 32'h0);
    advance();

    // Fill every entry with 0x1234 and claim it, then reset mid-cycle.
    for (int a = 0; a < 8; a++) begin
      apply(1, 3'(a), 16'h1234, 1, 3'(a), 3'(a), 3'(a));
      advance();
    end
    apply(0, 3'd0, 16'h0, 0, 3'd0, 3'd4, 3'd1);
    chk("fill_rd4_a", 32'(rd_data_a[15:0]), 32'h1234);
    chk("fill_busy_a", 32'(busy_a), 32'hff);
    reset_pulse();

    // Basic write then read on both ports.
    apply(1, 3'd3, 16'hBEEF, 0, 3'd0, 3'd0, 3'd0);
    advance();
    apply(0, 3'd0, 16'h0, 0, 3'd0, 3'd3, 3'd3);
    chk("basic_a_p0", 32'(rd_data_a[15:0]), 32'hBEEF);
    chk("basic_a_p1", 32'(rd_data_a[31:16]), 32'hBEEF);
    advance();
    apply(0, 3'd0, 16'h0, 0, 3'd0, 3'd3, 3'd3);
    chk("basic_b_p0", 32'(rd_data_b[15:0]), 32'hBEEF);
    chk("basic_b_p1", 32'(rd_data_b[31:16]), 32'hBEEF);
    advance();

    // Bypass versus stale read.
    apply(1, 3'd5, 16'h0001, 0, 3'd0, 3'd0, 3'd0);
    advance();
    apply(1, 3'd5, 16'hA5A5, 0, 3'd0, 3'd5, 3'd0);
    chk("bypass_a", 32'(rd_data_a[15:0]), 32'hA5A5);
    advance();
    apply(0, 3'd0, 16'h0, 0, 3'd0, 3'd5, 3'd0);
    chk("no_bypass_b", 32'(rd_data_b[15:0]), 32'h0001);
    advance();
    apply(0, 3'd0, 16'h0, 0, 3'd0, 3'd5, 3'd5);
    advance();

    // Entry 0: hardwired zero in dut_b, ordinary in dut_a.
    apply(1, 3'd0, 16'hFFFF, 1, 3'd0, 3'd0, 3'd0);
    advance();
    apply(0, 3'd0, 16'h0, 0, 3'd0, 3'd0, 3'd0);
    chk("zero_busy0_b", 32'(busy_b[0]), 32'h0);
    chk("zero_rd_busy_b", 32'(rd_busy_b[0]), 32'h0);
    chk("zero_rd0_b", 32'(rd_data_b[15:0]), 32'h0);
    chk("nonzero_rd0_a", 32'(rd_data_a[15:0]), 32'hFFFF);
    advance();

    // Scoreboard claim / collide / release on entry 2.
    apply(0, 3'd0, 16'h0, 1, 3'd2, 3'd2, 3'd2);
    advance();
    apply(1, 3'd2, 16'h2222, 1, 3'd2, 3'd2, 3'd2);
    chk("claim_busy2_a", 32'(busy_a[2]), 32'h1);
    chk("claim_rd_busy_a", 32'(rd_busy_a[0]), 32'h1);
    advance();
    apply(1, 3'd2, 16'h3333, 0, 3'd0, 3'd2, 3'd2);
    chk("set_wins_a", 32'(busy_a[2]), 32'h1);
    chk("no_fwd_rd_busy_b", 32'(rd_busy_b[1]), 32'h1);
    advance();
    apply(0, 3'd0, 16'h0, 0, 3'd0, 3'd2, 3'd2);
    chk("release_busy2_a", 32'(busy_a[2]), 32'h0);
    chk("release_busy2_b", 32'(busy_b[2]), 32'h0);
    advance();

    // Out-of-range address 7 on the DEPTH 6 build.
    apply(1, 3'd7, 16'h5555, 1, 3'd7, 3'd7, 3'd7);
    advance();
    apply(0, 3'd0, 16'h0, 0, 3'd0, 3'd7, 3'd6);
    chk("oor_busy_b", 32'(busy_b), 32'h0);
    chk("oor_rd7_b", 32'(rd_data_b[15:0]), 32'h0);
    chk("inrange_rd7_a", 32'(rd_data_a[15:0]), 32'h5555);
    advance();

    // Randomised traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        reset_pulse();
      end else begin
        apply(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
              1'($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        advance();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
